// File: rtl/sig_mixer_if.sv
// rtl/sig_mixer_if.sv - sample-tick, control and mixed-output bundle of the oscillator mixer
interface sig_mixer_if #(
   parameter int N_CH   = 4,
   parameter int W      = 16,
   parameter int GAIN_W = 4
);
   logic                     tick;
   logic                     gate;
   logic [N_CH-1:0]          en;
   logic [N_CH*GAIN_W-1:0]   gain;
   logic [N_CH*W-1:0]        sig_in;
   logic [W-1:0]             sig;
   logic                     valid;
   logic                     clip;
   logic                     busy;
   logic                     overrun;

   modport master (
      output tick, gate, en, gain, sig_in,
      input  sig, valid, clip, busy, overrun
   );

   modport slave (
      input  tick, gate, en, gain, sig_in,
      output sig, valid, clip, busy, overrun
   );
endinterface

// File: rtl/sig_mixer.sv
// rtl/sig_mixer.sv - time-multiplexed N-channel mixer with gain, saturation and gate-driven level ramp
module sig_mixer #(
   parameter int N_CH      = 4,
   parameter int W         = 16,
   parameter int GAIN_W    = 4,
   parameter int RAMP_STEP = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   sig_mixer_if.slave bus
);
   localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int PW = W + GAIN_W;
   localparam int AW = PW + IW;
   localparam int SW = AW - 3;
   localparam logic [SW-1:0] SAT_MAX  = SW'({W{1'b1}});
   localparam logic [9:0]    STEP_UP  = 10'(RAMP_STEP);
   localparam logic [8:0]    STEP_DN  = 9'(RAMP_STEP);
   localparam logic [9:0]    LVL_MAX  = 10'd256;
   localparam logic [IW-1:0] LAST_IDX = IW'(N_CH - 1);

   typedef enum logic [1:0] {IDLE, ACC, SCALE} state_t;
   state_t state_q, state_d;

   // Shadow copies taken at the tick so mid-mix input changes cannot tear a sample
   logic [N_CH*W-1:0]      sh_sig;
   logic [N_CH-1:0]        sh_en;
   logic [N_CH*GAIN_W-1:0] sh_gain;
   logic                   sh_gate;

   logic [AW-1:0] acc;
   logic [IW-1:0] idx;
   logic [8:0]    level;

   logic [W-1:0]  sig_r;
   logic          valid_r, clip_r, busy_r, overrun_r;

   logic [W-1:0]      ch_sig;
   logic [GAIN_W-1:0] ch_gain;
   logic [PW-1:0]     term;

   logic [SW-1:0]  sum;
   logic           clip_d;
   logic [W-1:0]   sat;
   logic [9:0]     lvl_up;
   logic [8:0]     lvl_dn;
   logic [8:0]     level_d;
   logic [W+7:0]   scaled;
   logic [W-1:0]   sig_d;

   always_comb begin
      ch_sig  = sh_sig[idx*W +: W];
      ch_gain = sh_gain[idx*GAIN_W +: GAIN_W];
      term    = '0;
      if (sh_en[idx])
         term = PW'(ch_sig) * PW'(ch_gain);
   end

   // Gain 8 is unity, hence the fixed divide by 8 before saturation
   always_comb begin
      sum    = SW'(acc >> 3);
      clip_d = (sum > SAT_MAX);
      sat    = clip_d ? {W{1'b1}} : sum[W-1:0];
      lvl_up = {1'b0, level} + STEP_UP;
      lvl_dn = level - STEP_DN;
      if (sh_gate)
         level_d = (lvl_up > LVL_MAX) ? 9'd256 : lvl_up[8:0];
      else
         level_d = (level < STEP_DN) ? 9'd0 : lvl_dn;
      scaled = {{8{1'b0}}, sat} * {{(W-1){1'b0}}, level_d};
      sig_d  = W'(scaled >> 8);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.tick) state_d = ACC;
         ACC:     if (idx == LAST_IDX) state_d = SCALE;
         SCALE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_sig    <= '0;
         sh_en     <= '0;
         sh_gain   <= '0;
         sh_gate   <= 1'b0;
         acc       <= '0;
         idx       <= '0;
         level     <= '0;
         sig_r     <= '0;
         valid_r   <= 1'b0;
         clip_r    <= 1'b0;
         busy_r    <= 1'b0;
         overrun_r <= 1'b0;
      end else begin
         valid_r   <= 1'b0;
         overrun_r <= bus.tick && (state_q != IDLE);
         busy_r    <= (state_d != IDLE);
         case (state_q)
            IDLE: begin
               if (bus.tick) begin
                  sh_sig  <= bus.sig_in;
                  sh_en   <= bus.en;
                  sh_gain <= bus.gain;
                  sh_gate <= bus.gate;
                  acc     <= '0;
                  idx     <= '0;
               end
            end
            ACC: begin
               acc <= acc + AW'(term);
               idx <= idx + 1'b1;
            end
            SCALE: begin
               sig_r   <= sig_d;
               clip_r  <= clip_d;
               level   <= level_d;
               valid_r <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.sig     = sig_r;
   assign bus.valid   = valid_r;
   assign bus.clip    = clip_r;
   assign bus.busy    = busy_r;
   assign bus.overrun = overrun_r;
endmodule

// File: tb/tb_sig_mixer.sv
// tb/tb_sig_mixer.sv - directed vector bench for sig_mixer
module tb_sig_mixer;
   localparam int N_CH   = 4;
   localparam int W      = 16;
   localparam int GAIN_W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   sig_mixer_if #(.N_CH(N_CH), .W(W), .GAIN_W(GAIN_W)) bus ();

   sig_mixer #(.N_CH(N_CH), .W(W), .GAIN_W(GAIN_W), .RAMP_STEP(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string                  name;
      logic [N_CH-1:0]        en;
      logic [N_CH*GAIN_W-1:0] gain;
      logic [N_CH*W-1:0]      sig_in;
      logic [W-1:0]           exp_sig;
      logic                   exp_clip;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic apply(input logic [N_CH-1:0] e, input logic [N_CH*GAIN_W-1:0] g,
                        input logic [N_CH*W-1:0] s, input logic gt);
      bus.en     = e;
      bus.gain   = g;
      bus.sig_in = s;
      bus.gate   = gt;
   endtask

   // Called at a falling edge; drives tick for the next rising edge and samples after it
   task automatic step(input logic t);
      bus.tick = t;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_mix(input string name, output logic [W-1:0] s, output logic c);
      int   vcount;
      logic busy_ok;
      logic v_end;
      vcount  = 0;
      busy_ok = 1'b1;
      v_end   = 1'b0;
      s       = '0;
      c       = 1'b0;
      for (int k = 1; k <= N_CH + 2; k++) begin
         step(k == 1);
         if (bus.valid) vcount++;
         if (bus.busy !== (k <= N_CH + 1)) busy_ok = 1'b0;
         if (k == N_CH + 2) begin
            v_end = bus.valid;
            s     = bus.sig;
            c     = bus.clip;
         end
      end
      check({name, " valid_count"}, 64'(vcount), 64'd1);
      check({name, " valid_edge"}, 64'(v_end), 64'd1);
      check({name, " busy_window"}, 64'(busy_ok), 64'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] s;
      logic         c;
      int           vc;
      int           oc;
      logic [W-1:0] vs;

      vecs[0] = '{"unity",     4'b1111, {4{4'd8}}, {16'd4000, 16'd3000, 16'd2000, 16'd1000}, 16'd10000, 1'b0};
      vecs[1] = '{"gain_en",   4'b0011, {4'd8, 4'd8, 4'd15, 4'd4}, {16'd7, 16'd9, 16'd1000, 16'd1000}, 16'd2375, 1'b0};
      vecs[2] = '{"all_off",   4'b0000, {4'd8, 4'd8, 4'd15, 4'd4}, {16'd7, 16'd9, 16'd1000, 16'd1000}, 16'd0, 1'b0};
      vecs[3] = '{"saturate",  4'b1111, {4{4'd8}}, {4{16'hFFFF}}, 16'hFFFF, 1'b1};
      vecs[4] = '{"small",     4'b1111, {4{4'd8}}, {16'd4, 16'd3, 16'd2, 16'd1}, 16'd10, 1'b0};
      vecs[5] = '{"max_exact", 4'b0001, {4{4'd8}}, {16'd0, 16'd0, 16'd0, 16'hFFFF}, 16'hFFFF, 1'b0};
      vecs[6] = '{"max_plus1", 4'b0011, {4{4'd8}}, {16'd0, 16'd0, 16'd1, 16'hFFFF}, 16'hFFFF, 1'b1};

      bus.tick = 1'b0;
      apply('0, '0, '0, 1'b0);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset sig", 64'(bus.sig), 64'd0);
      check("reset valid", 64'(bus.valid), 64'd0);
      check("reset clip", 64'(bus.clip), 64'd0);
      check("reset busy", 64'(bus.busy), 64'd0);
      check("reset overrun", 64'(bus.overrun), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Ramp up from level 0: level after mix i is i, capped at 256
      apply(4'b0001, {4'd0, 4'd0, 4'd0, 4'd8}, 64'd25600, 1'b1);
      for (int i = 1; i <= 257; i++) begin
         run_mix("ramp_up", s, c);
         if (i == 1)   check("ramp first", 64'(s), 64'd100);
         if (i == 2)   check("ramp second", 64'(s), 64'd200);
         if (i == 256) check("ramp 256th", 64'(s), 64'd25600);
         if (i == 257) check("ramp 257th", 64'(s), 64'd25600);
      end

      for (int v = 0; v < 7; v++) begin
         apply(vecs[v].en, vecs[v].gain, vecs[v].sig_in, 1'b1);
         run_mix(vecs[v].name, s, c);
         check({vecs[v].name, " sig"}, 64'(s), 64'(vecs[v].exp_sig));
         check({vecs[v].name, " clip"}, 64'(c), 64'(vecs[v].exp_clip));
      end
      step(1'b0);
      step(1'b0);
      check("hold valid", 64'(bus.valid), 64'd0);
      check("hold sig", 64'(bus.sig), 64'(vecs[6].exp_sig));

      // Overrun inside ACC and input change after capture
      apply(4'b1111, {4{4'd8}}, {16'd4000, 16'd3000, 16'd2000, 16'd1000}, 1'b1);
      vc = 0;
      oc = 0;
      vs = '0;
      step(1'b1);
      bus.sig_in = {4{16'hFFFF}};
      bus.en     = 4'b0001;
      step(1'b0);
      step(1'b1);
      check("overrun pulse", 64'(bus.overrun), 64'd1);
      if (bus.overrun) oc++;
      for (int e = 4; e <= 9; e++) begin
         step(1'b0);
         if (bus.overrun) oc++;
         if (bus.valid) begin
            vc++;
            vs = bus.sig;
         end
      end
      check("overrun count", 64'(oc), 64'd1);
      check("overrun valid_count", 64'(vc), 64'd1);
      check("tearing sig", 64'(vs), 64'd10000);

      // Tick on the valid edge is an overrun; tick on the following edge starts a mix
      apply(4'b1111, {4{4'd8}}, {16'd4000, 16'd3000, 16'd2000, 16'd1000}, 1'b1);
      step(1'b1);
      for (int e = 2; e <= 5; e++) step(1'b0);
      step(1'b1);
      check("edge6 valid", 64'(bus.valid), 64'd1);
      check("edge6 sig", 64'(bus.sig), 64'd10000);
      check("edge6 overrun", 64'(bus.overrun), 64'd1);
      check("edge6 busy", 64'(bus.busy), 64'd0);
      step(1'b1);
      check("edge7 busy", 64'(bus.busy), 64'd1);
      check("edge7 overrun", 64'(bus.overrun), 64'd0);
      check("edge7 valid", 64'(bus.valid), 64'd0);
      for (int e = 8; e <= 11; e++) step(1'b0);
      step(1'b0);
      check("edge12 valid", 64'(bus.valid), 64'd1);
      check("edge12 sig", 64'(bus.sig), 64'd10000);

      // Release ramp from level 256
      apply(4'b0001, {4'd0, 4'd0, 4'd0, 4'd8}, 64'd25600, 1'b0);
      run_mix("ramp_down", s, c);
      check("release first", 64'(s), 64'd25500);
      for (int i = 1; i <= 256; i++) begin
         run_mix("ramp_down", s, c);
         if (i == 254) check("release level1", 64'(s), 64'd100);
         if (i == 256) check("release end", 64'(s), 64'd0);
      end

      // Reset mid-mix
      apply(4'b0001, {4'd0, 4'd0, 4'd0, 4'd8}, 64'd25600, 1'b1);
      run_mix("pre_reset", s, c);
      check("pre_reset first", 64'(s), 64'd100);
      run_mix("pre_reset", s, c);
      check("pre_reset second", 64'(s), 64'd200);
      step(1'b1);
      step(1'b0);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midreset sig", 64'(bus.sig), 64'd0);
      check("midreset valid", 64'(bus.valid), 64'd0);
      check("midreset busy", 64'(bus.busy), 64'd0);
      check("midreset clip", 64'(bus.clip), 64'd0);
      check("midreset overrun", 64'(bus.overrun), 64'd0);
      vc = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.valid) vc++;
      end
      rst_n = 1'b1;
      repeat (4) begin
         step(1'b0);
         if (bus.valid) vc++;
      end
      check("midreset no_valid", 64'(vc), 64'd0);
      check("midreset sig_after", 64'(bus.sig), 64'd0);
      run_mix("post_reset", s, c);
      check("post_reset level_restart", 64'(s), 64'd100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sig_mixer.md
# sig_mixer

Parametrised, time-multiplexed waveform mixer that sums N_CH unsigned oscillator channels into one output sample. It applies per-channel enable and 4-bit gain, saturates the sum, and scales it by a gate-driven attack/release level that removes clicks on key press and release. It sits between the oscillator bank and the audio output stage and runs one mix per external sample tick.

## Interface
- N_CH, 4: number of input channels (≥2)
- W, 16: sample width, unsigned
- GAIN_W, 4: per-channel gain width; gain 8 = unity, result = sig*gain/8
- RAMP_STEP, 1: level change per mix (1..256)
- clk  in  1  system clock (1 MHz); all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- tick  in  1  sample strobe; starts one mix when idle
- gate  in  1  note on/off (button); drives level ramp
- en  in  N_CH  per-channel enable, bit i = channel i
- gain  in  N_CH*GAIN_W  channel i at [i*GAIN_W +: GAIN_W]
- sig_in  in  N_CH*W  channel i at [i*W +: W]
- sig  out  W  mixed output sample, held between updates
- valid  out  1  one-cycle pulse when sig updates
- clip  out  1  registered with sig: pre-level sum exceeded 2^W-1
- busy  out  1  high while a mix is in progress
- overrun  out  1  one-cycle pulse when tick arrives while busy

## Operation
- States: IDLE, ACC, SCALE.
- IDLE: on an edge with tick=1, capture sig_in, en, gain and gate into shadow registers. Clear the accumulator, set idx=0, set busy=1, go to ACC.
- ACC: each edge, add (en[idx] ? sig[idx]*gain[idx] : 0) to the accumulator and increment idx. After idx=N_CH-1 is added, go to SCALE.
- Accumulator width is W+GAIN_W+clog2(N_CH); it never overflows.
- SCALE, on one edge:
  - sum = acc>>3; sat = min(sum, 2^W-1); clip = (sum > 2^W-1).
  - Level update, level is 9-bit, range 0..256: if captured gate=1, level = min(level+RAMP_STEP, 256); else level = max(level-RAMP_STEP, 0).
  - sig = (sat*level_new)>>8, so level 256 = unity.
  - Assert valid, clear busy, return to IDLE.
- Shadow capture prevents tearing: input changes during ACC do not affect the current mix.
- tick in ACC or SCALE is ignored and raises overrun for one cycle; no mix is queued.
- en=0 on all channels still produces a mix: sig=0, valid=1.
- Level persists across mixes; it changes only in SCALE.

## Timing
- Reset (async assert) clears everything: sig=0, valid=0, clip=0, busy=0, overrun=0, level=0, state=IDLE, accumulator=0, idx=0. Release is synchronous to clk.
- Reset mid-mix aborts the mix: no valid pulse, and sig remains 0.
- Latency: count the tick-sampling edge as edge 1. ACC occupies edges 2..N_CH+1. sig, clip and valid update on edge N_CH+2. valid is high for exactly that one cycle.
- Throughput: one mix per N_CH+2 cycles.
- busy rises on edge 1 and falls on edge N_CH+2.
- A tick coincident with edge N_CH+2 is an overrun.
- A tick on the edge after the valid edge is accepted.
- overrun is registered: it pulses in the cycle after the offending tick edge.

## Test plan
- Unity mix (N_CH=4): pre-ramp level to 256 with gate=1 for 256 ticks. Then gain=8 on all channels, en=4'b1111, sig_in 1000/2000/3000/4000, tick -> sig=10000, clip=0, valid on edge 6 only, busy high on edges 1–5.
- Gain and enable: level=256, ch0=1000 gain 4, ch1=1000 gain 15, ch2/ch3 disabled with nonzero data -> sig=2375. Then en=0000 -> sig=0, valid=1.
- Saturation: level=256, all channels 0xFFFF at gain 8 -> sig=0xFFFF, clip=1. Next mix with small inputs -> clip=0.
- Ramp: from reset, ch0 only, 25600 at gain 8, gate=1, RAMP_STEP=1.
  - First mix -> sig=100.
  - 256th mix -> 25600.
  - 257th -> 25600.
  - gate=0, next mix -> 25500.
  - 256 further mixes -> 0.
- Overrun and tearing: tick, then tick again on edge 3 -> overrun pulses once, exactly one valid. Change sig_in on edge 2 -> result uses the captured values.
- Reset mid-mix: assert rst_n=0 asynchronously on edge 3 of a mix -> all outputs 0 immediately, no valid. The next tick after release completes normally with level restarting at 0.
